// File: rtl/pipe_ex_mdu.sv
// Iterative EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Runs mult/multu/div/divu in 32 iterations and stalls the front end while busy.
module pipe_ex_mdu #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             estart,
   input  logic [1:0]       eop,
   input  logic             emthi,
   input  logic             emtlo,
   input  logic [WIDTH-1:0] ea,
   input  logic [WIDTH-1:0] eb,
   output logic             estall,
   output logic [WIDTH-1:0] ehi,
   output logic [WIDTH-1:0] elo,
   output logic             ebusy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]    ONE_C  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0]    LAST_C = {CNTW{1'b1}};

   state_t             state;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [CNTW-1:0]    cnt;
   logic [1:0]         op;
   logic               neg_q;
   logic               neg_r;
   logic               dz;
   logic [WIDTH-1:0]   bmag;
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH:0]     madd;
   logic [WIDTH:0]     rsh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      mag = (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      neg_w = en ? (~v + ONE_W) : v;
   endfunction

   // One shift-add (multiply) or restoring shift-subtract (divide) step on acc.
   always_comb begin
      madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? bmag : {WIDTH{1'b0}})};
      rsh  = acc[2*WIDTH-1:WIDTH-1];
      diff = rsh - {1'b0, bmag};
      if (op[1]) begin
         if (!diff[WIDTH]) begin
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {madd, acc[WIDTH-1:1]};
      end
   end

   // Sign fix-up; with a zero divisor the remainder path already yields the dividend.
   always_comb begin
      prod = neg_q ? (~acc + ONE_2W) : acc;
      if (op[1]) begin
         res_hi = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
         res_lo = dz ? {WIDTH{1'b1}} : neg_w(acc[WIDTH-1:0], neg_q);
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   always_comb begin
      estall = ~reset & (((state == IDLE) & estart) | (state == RUN));
      ebusy  = ~reset & (state != IDLE);
   end

   assign ehi = hi;
   assign elo = lo;

   // Control FSM, iteration datapath and HI/LO registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         hi    <= {WIDTH{1'b0}};
         lo    <= {WIDTH{1'b0}};
         cnt   <= {CNTW{1'b0}};
         op    <= 2'b00;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
         bmag  <= {WIDTH{1'b0}};
         acc   <= {(2*WIDTH){1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (estart) begin
                  acc   <= {{WIDTH{1'b0}}, mag(ea, ~eop[0])};
                  bmag  <= mag(eb, ~eop[0]);
                  op    <= eop;
                  neg_q <= ~eop[0] & (ea[WIDTH-1] ^ eb[WIDTH-1]);
                  neg_r <= ~eop[0] & ea[WIDTH-1];
                  dz    <= (eb == {WIDTH{1'b0}});
                  cnt   <= {CNTW{1'b0}};
                  state <= RUN;
               end else begin
                  if (emthi) hi <= ea;
                  if (emtlo) lo <= ea;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + ONE_C;
               if (cnt == LAST_C) state <= DONE;
            end
            DONE: begin
               hi    <= res_hi;
               lo    <= res_lo;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ex_mdu.sv
// Self-checking bench for pipe_ex_mdu: vector table through a result scoreboard
// plus hand-written mthi/mtlo, priority and mid-operation reset sequences.
module tb_pipe_ex_mdu;

   logic        clock = 1'b0;
   logic        reset;
   logic        estart;
   logic [1:0]  eop;
   logic        emthi;
   logic        emtlo;
   logic [31:0] ea;
   logic [31:0] eb;
   logic        estall;
   logic [31:0] ehi;
   logic [31:0] elo;
   logic        ebusy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   vec_t vecs[11];
   res_t sb[$];

   pipe_ex_mdu dut (
      .clock(clock), .reset(reset), .estart(estart), .eop(eop),
      .emthi(emthi), .emtlo(emtlo), .ea(ea), .eb(eb),
      .estall(estall), .ehi(ehi), .elo(elo), .ebusy(ebusy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Run one operation with estart held through DONE, as a frozen ID/EX would.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] xhi, input logic [31:0] xlo,
                         input logic with_mt);
      int n;
      logic [31:0] hi0, lo0;
      res_t r;
      hi0 = ehi;
      lo0 = elo;
      r.hi = xhi;
      r.lo = xlo;
      sb.push_back(r);
      @(negedge clock);
      estart = 1'b1; eop = op; ea = a; eb = b;
      emthi = with_mt; emtlo = with_mt;
      #1;
      n = 0;
      while (estall && n < 100) begin
         n++;
         @(negedge clock);
         #1;
         if (n == 1) begin
            emthi = 1'b0; emtlo = 1'b0;
            if (with_mt) begin
               check({name, " hi kept"}, ehi, hi0);
               check({name, " lo kept"}, elo, lo0);
            end
         end
      end
      check({name, " stall cycles"}, n, 33);
      @(negedge clock);
      estart = 1'b0;
      #1;
      check({name, " idle busy"}, {31'd0, ebusy}, 32'd0);
      check({name, " idle stall"}, {31'd0, estall}, 32'd0);
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
      end else begin
         r = sb.pop_front();
         check({name, " hi"}, ehi, r.hi);
         check({name, " lo"}, elo, r.lo);
      end
   endtask

   initial begin
      vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      vecs[7]  = '{2'b10, 32'hFFFFEDCC, 32'h00000000, 32'hFFFFEDCC, 32'hFFFFFFFF};
      vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[10] = '{2'b00, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};

      reset = 1'b1; estart = 1'b0; eop = 2'b00; emthi = 1'b0; emtlo = 1'b0;
      ea = 32'd0; eb = 32'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset hi", ehi, 32'd0);
      check("reset lo", elo, 32'd0);
      check("reset stall", {31'd0, estall}, 32'd0);
      check("reset busy", {31'd0, ebusy}, 32'd0);

      // mthi then mtlo in consecutive idle cycles
      @(negedge clock); emthi = 1'b1; ea = 32'hA;
      @(negedge clock); emthi = 1'b0; emtlo = 1'b1; ea = 32'hB;
      @(negedge clock); emtlo = 1'b0; #1;
      check("mthi", ehi, 32'hA);
      check("mtlo", elo, 32'hB);
      @(negedge clock); emthi = 1'b1; emtlo = 1'b1; ea = 32'h99;
      @(negedge clock); emthi = 1'b0; emtlo = 1'b0; #1;
      check("mthi+mtlo hi", ehi, 32'h99);
      check("mthi+mtlo lo", elo, 32'h99);

      // estart wins over emthi/emtlo in the same IDLE cycle
      run_op("start prio", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, 1'b0);
      end

      // Reset mid-RUN: abort with no later HI/LO write
      @(negedge clock);
      estart = 1'b1; eop = 2'b01; ea = 32'h12345678; eb = 32'h9;
      repeat (10) @(negedge clock);
      reset = 1'b1; estart = 1'b0;
      #1;
      check("midrst stall", {31'd0, estall}, 32'd0);
      check("midrst busy", {31'd0, ebusy}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst hi", ehi, 32'd0);
      check("midrst lo", elo, 32'd0);
      repeat (40) @(negedge clock);
      #1;
      check("midrst hi later", ehi, 32'd0);
      check("midrst lo later", elo, 32'd0);
      check("midrst busy later", {31'd0, ebusy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ex_mdu.md
Name: pipe_ex_mdu

Overview:
- Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operands ea/eb plus decoded MDU control).
- Executes MIPS mult/multu/div/divu in 32 iteration cycles and owns the architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Raises a stall to freeze PC, IF/ID and ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW = WIDTH.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- estart  in  1  EX holds a valid mult/multu/div/divu instruction
- eop  in  2  00 mult, 01 multu, 10 div, 11 divu
- emthi  in  1  write ea into HI (mthi)
- emtlo  in  1  write ea into LO (mtlo)
- ea  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data)
- eb  in  WIDTH  rt operand (multiplier / divisor)
- estall  out  1  freeze upstream stages and the ID/EX register; insert bubble into EX/MEM
- ehi  out  WIDTH  current HI (mfhi source)
- elo  out  WIDTH  current LO (mflo source)
- ebusy  out  1  state is not IDLE (debug/status)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, HI=0, LO=0, counter=0, internal operand/accumulator regs=0; estall=0 and ebusy=0 while reset is high. Reset mid-operation aborts the operation with no HI/LO update.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - estart=1: estall=1 combinationally. Latch magnitudes of ea/eb (two's-complement absolute value for signed ops; |−2^31| = 0x80000000 as unsigned). Latch the result sign flags, eop, and the divide-by-zero flag (eb==0). Counter=0, go to RUN.
  - estart=0 with emthi/emtlo: HI<=ea and/or LO<=ea. Both may be high together.
  - estart has priority over emthi/emtlo if decode ever asserts them together.
- RUN: estall=1. One iteration per cycle; counter increments. Leave for DONE on the cycle the counter equals 31, i.e. after exactly 32 iterations.
  - Multiply: radix-2 shift-add on a 2*WIDTH unsigned accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- DONE (exactly one cycle): estall=0, so the instruction leaves EX at this edge. Write the fixed-up result to HI/LO. estart, emthi and emtlo are ignored. Next state is IDLE.
- Total stall: 33 cycles (1 accept + 32 RUN). HI/LO are visible on ehi/elo the cycle after DONE.
- Sign fix-up:
  - mult: negate the 64-bit product if signs differ.
  - div: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (div or divu): LO=0xFFFFFFFF, HI=ea as latched. Still takes 32 cycles.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No exception is raised.
- ehi and elo are register outputs; they never expose partial results.
- ebusy = (state != IDLE).

Test Plan:
- Reset: assert reset 2 cycles mid-RUN -> state IDLE, ehi=elo=0, estall=0; no HI/LO write afterwards.
- multu 0xFFFFFFFF × 0xFFFFFFFF -> estall high exactly 33 cycles. After DONE: HI=0xFFFFFFFE, LO=0x00000001.
- mult −7 (0xFFFFFFF9) × 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also mult 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- div −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100 / 7 -> LO=14, HI=2. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, after 32 RUN cycles.
- Back-to-back:
  - mthi 0xA, mtlo 0xB in consecutive idle cycles -> ehi=0xA, elo=0xB one cycle later.
  - estart held high through DONE -> no second operation starts.
  - emthi asserted with estart in IDLE -> HI unchanged by mthi.
